// File: rtl/vdp_io_port.sv
// vdp_io_port: Z80-facing I/O front end of the VDP.
// Decodes IORQ_L/RD_L/WR_L accesses to ports 0xBE (data) and 0xBF (control),
// owns the 14-bit address register, 2-bit code register and the read-ahead
// buffer, and issues VRAM, CRAM and VDP register writes plus VRAM prefetches.
// Optional build macro: VDP_IO_GG_CRAM_EN selects the Game Gear 12-bit
// palette path (two byte writes per CRAM entry); undefined gives SMS 6-bit CRAM.
module vdp_io_port #(
  parameter int unsigned READ_LAT    = 2,  // io_re to io_data_out valid, >= 1
  parameter int unsigned SYNC_STAGES = 2   // strobe synchronizer depth, >= 2
) (
  input  logic        clk_100,
  input  logic        rst_L,
  input  logic        IORQ_L,
  input  logic        RD_L,
  input  logic        WR_L,
  input  logic [7:0]  addr_bus,
  input  logic [7:0]  cpu_data_in,
  output logic [7:0]  cpu_data_out,
  output logic        cpu_data_oe,
  output logic [13:0] io_addr,
  output logic [7:0]  vram_wdata,
  output logic        io_we,
  output logic        io_re,
  input  logic [7:0]  io_data_out,
  output logic [4:0]  cram_addr,
  output logic [11:0] cram_wdata,
  output logic        cram_we,
  output logic [3:0]  reg_addr,
  output logic [7:0]  reg_data,
  output logic        reg_we,
  input  logic [7:0]  status_in,
  output logic        status_rd
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PREFETCH,
    S_WAIT
  } state_t;

  localparam int unsigned CNT_W = $clog2(READ_LAT + 1) + 1;

  // Strobe synchronizers
  logic [SYNC_STAGES-1:0] iorq_sync_q, iorq_sync_d;
  logic [SYNC_STAGES-1:0] rd_sync_q, rd_sync_d;
  logic [SYNC_STAGES-1:0] wr_sync_q, wr_sync_d;

  logic rd_act, wr_act;
  logic rd_act_q, rd_act_d;
  logic wr_act_q, wr_act_d;
  logic rd_rise, wr_rise, port_hit;

  // Event decoded from the bus this cycle
  logic       new_ev;
  logic       new_wr;
  logic       new_ctrl;
  logic [7:0] new_data;

  // Event being executed this cycle (fresh or replayed from the pending slot)
  logic       ev_valid;
  logic       ev_wr;
  logic       ev_ctrl;
  logic [7:0] ev_data;

  // Core state
  state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [13:0] addr_q, addr_d;
  logic [1:0]  code_q, code_d;
  logic        flag_q, flag_d;
  logic [7:0]  rbuf_q, rbuf_d;

  // Pending slot
  logic       pend_valid_q, pend_valid_d;
  logic       pend_wr_q, pend_wr_d;
  logic       pend_ctrl_q, pend_ctrl_d;
  logic [7:0] pend_data_q, pend_data_d;

  // Registered outputs
  logic [7:0]  cpu_data_out_q, cpu_data_out_d;
  logic        cpu_data_oe_q, cpu_data_oe_d;
  logic [13:0] io_addr_q, io_addr_d;
  logic [7:0]  vram_wdata_q, vram_wdata_d;
  logic        io_we_q, io_we_d;
  logic [4:0]  cram_addr_q, cram_addr_d;
  logic [11:0] cram_wdata_q, cram_wdata_d;
  logic        cram_we_q, cram_we_d;
  logic [3:0]  reg_addr_q, reg_addr_d;
  logic [7:0]  reg_data_q, reg_data_d;
  logic        reg_we_q, reg_we_d;
  logic        status_rd_q, status_rd_d;

`ifdef VDP_IO_GG_CRAM_EN
  logic [7:0] cram_lo_q, cram_lo_d;
`endif

  // Address bits between the port-select fields are don't-care for decoding
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr_bus[5:1];

  // Synchronizer shift and strobe edge detection
  always_comb begin
    iorq_sync_d = {iorq_sync_q[SYNC_STAGES-2:0], IORQ_L};
    rd_sync_d   = {rd_sync_q[SYNC_STAGES-2:0], RD_L};
    wr_sync_d   = {wr_sync_q[SYNC_STAGES-2:0], WR_L};
    rd_act      = ~iorq_sync_q[SYNC_STAGES-1] & ~rd_sync_q[SYNC_STAGES-1];
    wr_act      = ~iorq_sync_q[SYNC_STAGES-1] & ~wr_sync_q[SYNC_STAGES-1];
    rd_act_d    = rd_act;
    wr_act_d    = wr_act;
    rd_rise     = rd_act & ~rd_act_q;
    wr_rise     = wr_act & ~wr_act_q;
    port_hit    = (addr_bus[7:6] == 2'b10);
    new_ev      = port_hit & (rd_rise | wr_rise);
    new_wr      = wr_rise;
    new_ctrl    = addr_bus[0];
    new_data    = wr_rise ? cpu_data_in : status_in;
  end

  // Next-state: event dispatch, prefetch FSM and output pulses
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    addr_d         = addr_q;
    code_d         = code_q;
    flag_d         = flag_q;
    rbuf_d         = rbuf_q;
    pend_valid_d   = pend_valid_q;
    pend_wr_d      = pend_wr_q;
    pend_ctrl_d    = pend_ctrl_q;
    pend_data_d    = pend_data_q;
    cpu_data_out_d = cpu_data_out_q;
    cpu_data_oe_d  = rd_act & port_hit;
    io_addr_d      = io_addr_q;
    vram_wdata_d   = vram_wdata_q;
    io_we_d        = 1'b0;
    cram_addr_d    = cram_addr_q;
    cram_wdata_d   = cram_wdata_q;
    cram_we_d      = 1'b0;
    reg_addr_d     = reg_addr_q;
    reg_data_d     = reg_data_q;
    reg_we_d       = 1'b0;
    status_rd_d    = 1'b0;
`ifdef VDP_IO_GG_CRAM_EN
    cram_lo_d      = cram_lo_q;
`endif
    ev_valid       = 1'b0;
    ev_wr          = 1'b0;
    ev_ctrl        = 1'b0;
    ev_data        = '0;

    // A replayed pending event runs first; a simultaneous fresh one takes the slot
    case (state_q)
      S_IDLE: begin
        if (pend_valid_q) begin
          ev_valid     = 1'b1;
          ev_wr        = pend_wr_q;
          ev_ctrl      = pend_ctrl_q;
          ev_data      = pend_data_q;
          pend_valid_d = new_ev;
          pend_wr_d    = new_wr;
          pend_ctrl_d  = new_ctrl;
          pend_data_d  = new_data;
        end else if (new_ev) begin
          ev_valid = 1'b1;
          ev_wr    = new_wr;
          ev_ctrl  = new_ctrl;
          ev_data  = new_data;
        end
      end
      S_PREFETCH: begin
        state_d = S_WAIT;
        cnt_d   = CNT_W'(1);
        if (new_ev && !pend_valid_q) begin
          pend_valid_d = 1'b1;
          pend_wr_d    = new_wr;
          pend_ctrl_d  = new_ctrl;
          pend_data_d  = new_data;
        end
      end
      S_WAIT: begin
        if (cnt_q == CNT_W'(READ_LAT)) begin
          rbuf_d  = io_data_out;
          addr_d  = addr_q + 14'd1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (new_ev && !pend_valid_q) begin
          pend_valid_d = 1'b1;
          pend_wr_d    = new_wr;
          pend_ctrl_d  = new_ctrl;
          pend_data_d  = new_data;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (ev_valid) begin
      flag_d = 1'b0;
      if (ev_wr && ev_ctrl) begin
        if (!flag_q) begin
          addr_d[7:0] = ev_data;
          flag_d      = 1'b1;
        end else begin
          addr_d[13:8] = ev_data[5:0];
          code_d       = ev_data[7:6];
          case (ev_data[7:6])
            2'd0: state_d = S_PREFETCH;
            2'd2: begin
              reg_we_d   = 1'b1;
              reg_addr_d = ev_data[3:0];
              reg_data_d = addr_q[7:0];
            end
            default: ;
          endcase
        end
      end else if (ev_wr) begin
        rbuf_d = ev_data;
        addr_d = addr_q + 14'd1;
        if (code_q == 2'd3) begin
`ifdef VDP_IO_GG_CRAM_EN
          if (!addr_q[0]) begin
            cram_lo_d = ev_data;
          end else begin
            cram_we_d    = 1'b1;
            cram_addr_d  = addr_q[5:1];
            cram_wdata_d = {ev_data[3:0], cram_lo_q};
          end
`else
          cram_we_d    = 1'b1;
          cram_addr_d  = addr_q[4:0];
          cram_wdata_d = {6'b0, ev_data[5:0]};
`endif
        end else begin
          io_we_d      = 1'b1;
          io_addr_d    = addr_q;
          vram_wdata_d = ev_data;
        end
      end else if (!ev_ctrl) begin
        cpu_data_out_d = rbuf_q;
        state_d        = S_PREFETCH;
      end else begin
        cpu_data_out_d = ev_data;
        status_rd_d    = 1'b1;
      end
    end

    // io_addr is loaded as PREFETCH is entered so it is stable while io_re is high
    if (state_d == S_PREFETCH) begin
      io_addr_d = addr_d;
    end
  end

  // State and output registers
  always_ff @(posedge clk_100 or negedge rst_L) begin
    if (!rst_L) begin
      iorq_sync_q    <= '1;
      rd_sync_q      <= '1;
      wr_sync_q      <= '1;
      rd_act_q       <= 1'b0;
      wr_act_q       <= 1'b0;
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      addr_q         <= '0;
      code_q         <= '0;
      flag_q         <= 1'b0;
      rbuf_q         <= '0;
      pend_valid_q   <= 1'b0;
      pend_wr_q      <= 1'b0;
      pend_ctrl_q    <= 1'b0;
      pend_data_q    <= '0;
      cpu_data_out_q <= '0;
      cpu_data_oe_q  <= 1'b0;
      io_addr_q      <= '0;
      vram_wdata_q   <= '0;
      io_we_q        <= 1'b0;
      cram_addr_q    <= '0;
      cram_wdata_q   <= '0;
      cram_we_q      <= 1'b0;
      reg_addr_q     <= '0;
      reg_data_q     <= '0;
      reg_we_q       <= 1'b0;
      status_rd_q    <= 1'b0;
`ifdef VDP_IO_GG_CRAM_EN
      cram_lo_q      <= '0;
`endif
    end else begin
      iorq_sync_q    <= iorq_sync_d;
      rd_sync_q      <= rd_sync_d;
      wr_sync_q      <= wr_sync_d;
      rd_act_q       <= rd_act_d;
      wr_act_q       <= wr_act_d;
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      addr_q         <= addr_d;
      code_q         <= code_d;
      flag_q         <= flag_d;
      rbuf_q         <= rbuf_d;
      pend_valid_q   <= pend_valid_d;
      pend_wr_q      <= pend_wr_d;
      pend_ctrl_q    <= pend_ctrl_d;
      pend_data_q    <= pend_data_d;
      cpu_data_out_q <= cpu_data_out_d;
      cpu_data_oe_q  <= cpu_data_oe_d;
      io_addr_q      <= io_addr_d;
      vram_wdata_q   <= vram_wdata_d;
      io_we_q        <= io_we_d;
      cram_addr_q    <= cram_addr_d;
      cram_wdata_q   <= cram_wdata_d;
      cram_we_q      <= cram_we_d;
      reg_addr_q     <= reg_addr_d;
      reg_data_q     <= reg_data_d;
      reg_we_q       <= reg_we_d;
      status_rd_q    <= status_rd_d;
`ifdef VDP_IO_GG_CRAM_EN
      cram_lo_q      <= cram_lo_d;
`endif
    end
  end

  assign cpu_data_out = cpu_data_out_q;
  assign cpu_data_oe  = cpu_data_oe_q;
  assign io_addr      = io_addr_q;
  assign vram_wdata   = vram_wdata_q;
  assign io_we        = io_we_q;
  assign io_re        = (state_q == S_PREFETCH);
  assign cram_addr    = cram_addr_q;
  assign cram_wdata   = cram_wdata_q;
  assign cram_we      = cram_we_q;
  assign reg_addr     = reg_addr_q;
  assign reg_data     = reg_data_q;
  assign reg_we       = reg_we_q;
  assign status_rd    = status_rd_q;

endmodule
